regbank_wr_sched: RTL and testbench

Write-port scheduler for the 32-entry MIPS register bank. Shares the bank's single write port between the CPU writeback stage, a debug/host write requester and an internal clear sequencer that zeroes every register on command. Sits between the writeback stage, the debug bridge and the register bank's RegWrite/WriteReg/WriteData inputs; it also stalls the CPU while it holds the port.

---
 rtl/regbank_wr_sched.sv | 160 ++++++++++++++++
 tb/tb_regbank_wr_sched.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/regbank_wr_sched.sv
// regbank_wr_sched
//   Write-port scheduler for the 32-entry MIPS register bank. The bank has a
//   single write port shared by the CPU writeback stage, a debug/host write
//   requester (through a one-entry buffer) and a clear sequencer that zeroes
//   every register on command. The CPU is stalled whenever it loses the port.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   i_cpu_we/waddr/wdata   writeback write request (ignored while o_cpu_stall)
//   o_cpu_stall       CPU must hold its writeback this cycle
//   i_dbg_valid/addr/data, o_dbg_ready   debug write handshake
//   i_clr_start       one-cycle pulse starting the clear sequence
//   o_clr_busy        clear sequence active
//   o_rf_we/waddr/wdata    bank RegWrite / WriteReg / WriteData
//
// Configuration macro
//   REGSCHED_ZERO_GUARD_EN : CPU/debug writes to register 0 are consumed
//                            without asserting o_rf_we (clear still writes r0).

module regbank_wr_sched #(
  parameter int REG_FILE_DEPTH = 32,
  parameter int REG_ADDR_W     = 5,
  parameter int DATA_32_W      = 32,
  parameter int STARVE_LIMIT   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_cpu_we,
  input  logic [REG_ADDR_W-1:0] i_cpu_waddr,
  input  logic [DATA_32_W-1:0]  i_cpu_wdata,
  output logic                  o_cpu_stall,
  input  logic                  i_dbg_valid,
  output logic                  o_dbg_ready,
  input  logic [REG_ADDR_W-1:0] i_dbg_addr,
  input  logic [DATA_32_W-1:0]  i_dbg_data,
  input  logic                  i_clr_start,
  output logic                  o_clr_busy,
  output logic                  o_rf_we,
  output logic [REG_ADDR_W-1:0] o_rf_waddr,
  output logic [DATA_32_W-1:0]  o_rf_wdata
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_LAST = SW'(STARVE_LIMIT - 1);
  localparam logic [REG_ADDR_W-1:0] CLR_LAST = REG_ADDR_W'(REG_FILE_DEPTH - 1);

`ifdef REGSCHED_ZERO_GUARD_EN
  localparam bit ZERO_GUARD = 1'b1;
`else
  localparam bit ZERO_GUARD = 1'b0;
`endif

  typedef enum logic [1:0] {RUN, CLEAR, DRAIN} state_t;

  state_t                r_state;
  logic                  r_pend;
  logic [REG_ADDR_W-1:0] r_pendAddr;
  logic [DATA_32_W-1:0]  r_pendData;
  logic [SW-1:0]         r_starveCnt;
  logic [REG_ADDR_W-1:0] r_clrCnt;

  state_t                w_nextState;
  logic [SW-1:0]         w_nextStarve;
  logic [REG_ADDR_W-1:0] w_nextClr;
  logic                  w_pendClear;
  logic                  w_accept;

  assign o_dbg_ready = !r_pend && (r_state != CLEAR);
  assign w_accept    = i_dbg_valid && o_dbg_ready;

  // Next-state and port arbitration. In RUN the CPU always wins; a buffered
  // debug write that has been blocked STARVE_LIMIT cycles gets a DRAIN cycle,
  // so DRAIN is entered when the counter is about to reach the limit. A clear
  // request takes priority over a pending drain; the buffer survives it.
  always_comb begin
    w_nextState  = r_state;
    w_nextStarve = r_starveCnt;
    w_nextClr    = r_clrCnt;
    w_pendClear  = 1'b0;
    o_cpu_stall  = 1'b0;
    o_clr_busy   = 1'b0;
    o_rf_we      = 1'b0;
    o_rf_waddr   = '0;
    o_rf_wdata   = '0;
    case (r_state)
      RUN: begin
        if (i_cpu_we) begin
          o_rf_we    = !(ZERO_GUARD && (i_cpu_waddr == '0));
          o_rf_waddr = i_cpu_waddr;
          o_rf_wdata = i_cpu_wdata;
          if (r_pend) begin
            w_nextStarve = r_starveCnt + 1'b1;
            if (r_starveCnt == STARVE_LAST) w_nextState = DRAIN;
          end
        end else if (r_pend) begin
          o_rf_we      = !(ZERO_GUARD && (r_pendAddr == '0));
          o_rf_waddr   = r_pendAddr;
          o_rf_wdata   = r_pendData;
          w_pendClear  = 1'b1;
          w_nextStarve = '0;
        end
        if (i_clr_start) begin
          w_nextState  = CLEAR;
          w_nextClr    = '0;
          w_nextStarve = '0;
        end
      end
      DRAIN: begin
        o_cpu_stall  = 1'b1;
        o_rf_we      = !(ZERO_GUARD && (r_pendAddr == '0));
        o_rf_waddr   = r_pendAddr;
        o_rf_wdata   = r_pendData;
        w_pendClear  = 1'b1;
        w_nextStarve = '0;
        w_nextState  = RUN;
        if (i_clr_start) begin
          w_nextState = CLEAR;
          w_nextClr   = '0;
        end
      end
      CLEAR: begin
        o_cpu_stall = 1'b1;
        o_clr_busy  = 1'b1;
        o_rf_we     = 1'b1;
        o_rf_waddr  = r_clrCnt;
        w_nextClr   = r_clrCnt + 1'b1;
        if (r_clrCnt == CLR_LAST) begin
          w_nextState = RUN;
          w_nextClr   = '0;
        end
      end
      default: w_nextState = RUN;
    endcase
  end

  // State, counters and the one-entry debug buffer. A request can only be
  // accepted while the buffer is empty, so set and clear never collide.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= RUN;
      r_pend      <= 1'b0;
      r_pendAddr  <= '0;
      r_pendData  <= '0;
      r_starveCnt <= '0;
      r_clrCnt    <= '0;
    end else begin
      r_state     <= w_nextState;
      r_starveCnt <= w_nextStarve;
      r_clrCnt    <= w_nextClr;
      if (w_pendClear) begin
        r_pend <= 1'b0;
      end else if (w_accept) begin
        r_pend     <= 1'b1;
        r_pendAddr <= i_dbg_addr;
        r_pendData <= i_dbg_data;
      end
    end
  end

endmodule

// File: tb/tb_regbank_wr_sched.sv
// tb_regbank_wr_sched
//   Directed and random stimulus for regbank_wr_sched, checked every cycle
//   against a behavioural model of the write-port sharing rules.

module tb_regbank_wr_sched;

  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int LIMIT = 8;

`ifdef REGSCHED_ZERO_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          cpuWe;
  logic [AW-1:0] cpuWaddr;
  logic [DW-1:0] cpuWdata;
  logic          cpuStall;
  logic          dbgValid;
  logic          dbgReady;
  logic [AW-1:0] dbgAddr;
  logic [DW-1:0] dbgData;
  logic          clrStart;
  logic          clrBusy;
  logic          rfWe;
  logic [AW-1:0] rfWaddr;
  logic [DW-1:0] rfWdata;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;

  // Model: pending debug write, how long it has been blocked, whether a
  // forced drain is due, and how many clear writes remain.
  bit            mPend;
  logic [AW-1:0] mPendAddr;
  logic [DW-1:0] mPendData;
  int            mWait;
  bit            mDrain;
  int            mClearLeft;

  logic          expStall, expReady, expBusy, expWe;
  logic [AW-1:0] expWaddr;
  logic [DW-1:0] expWdata;

  always #5 clk = ~clk;

  regbank_wr_sched #(
    .REG_FILE_DEPTH(DEPTH), .REG_ADDR_W(AW), .DATA_32_W(DW), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst(rst),
    .i_cpu_we(cpuWe), .i_cpu_waddr(cpuWaddr), .i_cpu_wdata(cpuWdata),
    .o_cpu_stall(cpuStall),
    .i_dbg_valid(dbgValid), .o_dbg_ready(dbgReady),
    .i_dbg_addr(dbgAddr), .i_dbg_data(dbgData),
    .i_clr_start(clrStart), .o_clr_busy(clrBusy),
    .o_rf_we(rfWe), .o_rf_waddr(rfWaddr), .o_rf_wdata(rfWdata)
  );

  task automatic checkOne(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s cycle=%0d observed=%h expected=%h", tag, cycle, obs, exp);
    end
  endtask

  function automatic void computeExpected();
    expStall = 1'b0; expBusy = 1'b0; expReady = !mPend;
    expWe = 1'b0; expWaddr = '0; expWdata = '0;
    if (mClearLeft > 0) begin
      expStall = 1'b1; expBusy = 1'b1; expReady = 1'b0; expWe = 1'b1;
      expWaddr = AW'(DEPTH - mClearLeft);
    end else if (mDrain) begin
      expStall = 1'b1;
      expWe = !(GUARD && mPendAddr == 0); expWaddr = mPendAddr; expWdata = mPendData;
    end else if (cpuWe) begin
      expWe = !(GUARD && cpuWaddr == 0); expWaddr = cpuWaddr; expWdata = cpuWdata;
    end else if (mPend) begin
      expWe = !(GUARD && mPendAddr == 0); expWaddr = mPendAddr; expWdata = mPendData;
    end
  endfunction

  task automatic checkOutput();
    computeExpected();
    checkOne("cpu_stall", DW'(cpuStall), DW'(expStall));
    checkOne("dbg_ready", DW'(dbgReady), DW'(expReady));
    checkOne("clr_busy",  DW'(clrBusy),  DW'(expBusy));
    checkOne("rf_we",     DW'(rfWe),     DW'(expWe));
    checkOne("rf_waddr",  DW'(rfWaddr),  DW'(expWaddr));
    checkOne("rf_wdata",  rfWdata,       expWdata);
  endtask

  function automatic void updateModel();
    bit acc;
    if (rst) begin
      mPend = 0; mWait = 0; mDrain = 0; mClearLeft = 0;
    end else if (mClearLeft > 0) begin
      mClearLeft--;
    end else if (mDrain) begin
      mPend = 0; mWait = 0; mDrain = 0;
      if (clrStart) mClearLeft = DEPTH;
    end else begin
      acc = dbgValid && !mPend;
      if (cpuWe) begin
        if (mPend) begin
          mWait++;
          if (mWait == LIMIT) mDrain = 1;
        end
      end else if (mPend) begin
        mPend = 0; mWait = 0;
      end
      if (clrStart) begin
        mClearLeft = DEPTH; mDrain = 0; mWait = 0;
      end
      if (acc) begin
        mPend = 1; mPendAddr = dbgAddr; mPendData = dbgData;
      end
    end
  endfunction

  task automatic applyStimulus(input bit r, input bit we, input logic [AW-1:0] wa,
                               input logic [DW-1:0] wd, input bit dv,
                               input logic [AW-1:0] da, input logic [DW-1:0] dd,
                               input bit cs, input bit doCheck);
    rst = r; cpuWe = we; cpuWaddr = wa; cpuWdata = wd;
    dbgValid = dv; dbgAddr = da; dbgData = dd; clrStart = cs;
    #1;
    if (doCheck) checkOutput();
    @(posedge clk);
    updateModel();
    cycle++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, '0, '0, 0, '0, '0, 0, 1);
  endtask

  initial begin
    mPend = 0; mWait = 0; mDrain = 0; mClearLeft = 0;
    mPendAddr = '0; mPendData = '0;

    $display("[TB] reset");
    applyStimulus(1, 0, '0, '0, 0, '0, '0, 0, 0);
    applyStimulus(1, 0, '0, '0, 0, '0, '0, 0, 1);
    idle(1);

    $display("[TB] cpu write r5");
    applyStimulus(0, 1, 5'd5, 32'h1234, 0, '0, '0, 0, 1);

    $display("[TB] debug write r7 while cpu idle");
    applyStimulus(0, 0, '0, '0, 1, 5'd7, 32'hABCD, 0, 1);
    idle(3);

    $display("[TB] debug write r9 under continuous cpu writes");
    applyStimulus(0, 1, 5'd3, 32'h1, 1, 5'd9, 32'h9999, 0, 1);
    for (int i = 0; i < 12; i++)
      applyStimulus(0, 1, AW'(i + 10), $urandom, 1, 5'd20, 32'h2020, 0, 1);
    idle(3);

    $display("[TB] clear sequence");
    applyStimulus(0, 0, '0, '0, 0, '0, '0, 1, 1);
    for (int i = 0; i < DEPTH + 2; i++)
      applyStimulus(0, $urandom_range(0, 1), AW'($urandom), $urandom,
                    $urandom_range(0, 1), AW'($urandom), $urandom, 1, 1);
    idle(3);

    $display("[TB] reset during clear");
    applyStimulus(0, 0, '0, '0, 0, '0, '0, 1, 1);
    idle(12);
    applyStimulus(1, 0, '0, '0, 0, '0, '0, 0, 1);
    idle(3);

    $display("[TB] cpu write to r0");
    applyStimulus(0, 1, 5'd0, 32'hFFFF, 0, '0, '0, 0, 1);
    applyStimulus(0, 0, '0, '0, 1, 5'd0, 32'h5A5A, 0, 1);
    idle(2);

    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++)
      applyStimulus(($urandom_range(0, 149) == 0), ($urandom_range(0, 9) < 7),
                    AW'($urandom), $urandom, ($urandom_range(0, 9) < 4),
                    AW'($urandom), $urandom, ($urandom_range(0, 59) == 0), 1);
    idle(DEPTH + 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
